// File: rtl/ecc_scrub_reader.sv
// Background scrubber: sweeps every word of a Hamming(12,8)-protected memory, reports and counts errors.
// Define ECC_SCRUB_WRITEBACK_EN to write corrected words back; otherwise errors are report-only.
module ecc_scrub_reader #(
    parameter int ADDR_WIDTH   = 10,
    parameter int WIDTH        = 8,
    parameter int CODE_WIDTH   = 12,
    parameter int READ_LATENCY = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_en,
    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [CODE_WIDTH-1:0] o_din,
    input  logic [CODE_WIDTH-1:0] i_dout,
    output logic                  o_err_valid,
    output logic [ADDR_WIDTH-1:0] o_err_addr,
    output logic                  o_err_uncorr,
    output logic [15:0]           o_corr_cnt,
    output logic [15:0]           o_uncorr_cnt
);

`ifdef ECC_SCRUB_WRITEBACK_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    localparam int                    PARITY_BITS = CODE_WIDTH - WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;
    localparam logic [1:0]            WAIT_LAST   = 2'(READ_LATENCY >= 2 ? READ_LATENCY - 2 : 0);

    typedef enum logic [2:0] {IDLE, READ, WAIT, CHECK, WB, DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [1:0]              wait_q, wait_d;
    logic [CODE_WIDTH-1:0]   code_q, code_d;
    logic [15:0]             corr_q, corr_d;
    logic [15:0]             uncorr_q, uncorr_d;

    logic [PARITY_BITS-1:0]  syn;
    logic [CODE_WIDTH-1:0]   corrected;
    logic                    advance, busy, done, en, we, err_valid, err_uncorr;

    // Syndrome is the XOR of the Hamming positions (1-based) of every set bit.
    always_comb begin
        syn       = '0;
        corrected = i_dout;
        for (int p = 1; p <= CODE_WIDTH; p++) begin
            if (i_dout[p-1]) syn = syn ^ PARITY_BITS'(p);
        end
        for (int p = 1; p <= CODE_WIDTH; p++) begin
            if (syn == PARITY_BITS'(p)) corrected[p-1] = ~i_dout[p-1];
        end
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wait_d     = wait_q;
        code_d     = code_q;
        corr_d     = corr_q;
        uncorr_d   = uncorr_q;
        advance    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        en         = 1'b0;
        we         = 1'b0;
        err_valid  = 1'b0;
        err_uncorr = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    addr_d   = '0;
                    corr_d   = '0;
                    uncorr_d = '0;
                    state_d  = READ;
                end
            end
            READ: begin
                busy    = 1'b1;
                en      = 1'b1;
                wait_d  = '0;
                state_d = (READ_LATENCY == 1) ? CHECK : WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (wait_q == WAIT_LAST) state_d = CHECK;
                else                     wait_d  = wait_q + 2'd1;
            end
            CHECK: begin
                busy   = 1'b1;
                code_d = corrected;
                if (syn == '0) begin
                    advance = 1'b1;
                end else if (syn > PARITY_BITS'(CODE_WIDTH)) begin
                    err_valid  = 1'b1;
                    err_uncorr = 1'b1;
                    uncorr_d   = (uncorr_q == 16'hFFFF) ? uncorr_q : uncorr_q + 16'd1;
                    advance    = 1'b1;
                end else begin
                    err_valid = 1'b1;
                    corr_d    = (corr_q == 16'hFFFF) ? corr_q : corr_q + 16'd1;
                    if (WB_EN) state_d = WB;
                    else       advance = 1'b1;
                end
            end
            WB: begin
                busy    = 1'b1;
                en      = 1'b1;
                we      = WB_EN;
                advance = 1'b1;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if (addr_q == LAST_ADDR) begin
                state_d = DONE;
            end else begin
                addr_d  = addr_q + 1'b1;
                state_d = READ;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wait_q   <= '0;
            code_q   <= '0;
            corr_q   <= '0;
            uncorr_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wait_q   <= wait_d;
            code_q   <= code_d;
            corr_q   <= corr_d;
            uncorr_q <= uncorr_d;
        end
    end

    // NOTE: outputs are masked by reset so a write-back cut off by reset never reaches memory.
    assign o_busy       = busy & ~i_rst;
    assign o_done       = done & ~i_rst;
    assign o_en         = en & ~i_rst;
    assign o_we         = we & ~i_rst;
    assign o_addr       = i_rst ? '0 : addr_q;
    assign o_din        = i_rst ? '0 : code_q;
    assign o_err_valid  = err_valid & ~i_rst;
    assign o_err_addr   = i_rst ? '0 : addr_q;
    assign o_err_uncorr = err_uncorr & ~i_rst;
    assign o_corr_cnt   = i_rst ? '0 : corr_q;
    assign o_uncorr_cnt = i_rst ? '0 : uncorr_q;

endmodule
